red_pitaya_asg_sweep: RTL and testbench
=======================================

Name: red_pitaya_asg_sweep

Overview:
Frequency-sweep sequencer for one ASG channel. Drives the channel's phase-increment inputs (set_step_i / set_step_lo_i) through a linear staircase from a start step to a stop step, holding each step for a programmable dwell. Issues a pointer-reset pulse at sweep start and supports a repeat count. Sits in the dac_clk domain between the ASG register bank and red_pitaya_asg_ch.

Parameters:
RSZ, 14, table address width; the step word is RSZ+48 bits wide (RSZ+16 integer bits, 32 fractional bits).
CNT_W, 32, width of the dwell counter.

Ports:
dac_clk_i  in  1  DAC clock; the only clock in the block.
dac_rstn_i  in  1  reset, asynchronous, active-low.
start_i  in  1  single-cycle pulse; starts a sweep.
abort_i  in  1  single-cycle pulse; stops the sweep immediately.
cfg_start_i  in  RSZ+48  first step word.
cfg_stop_i  in  RSZ+48  final step word.
cfg_inc_i  in  RSZ+48  increment magnitude per stair (unsigned).
cfg_dwell_i  in  CNT_W  dac_clk cycles spent on each stair.
cfg_rep_i  in  16  extra repetitions after the first sweep; 16'hffff = infinite.
step_hi_o  out  RSZ+16  to set_step_i.
step_lo_o  out  32  to set_step_lo_i.
asg_rst_o  out  1  to set_rst_i; one-cycle pulse.
busy_o  out  1  high from LOAD until the sweep finishes or is aborted.
done_o  out  1  one-cycle pulse when the final sweep completes.
stair_o  out  16  stairs completed in the current pass; saturates at 16'hffff.

Behaviour:
- Reset values: step = 0, asg_rst_o = 0, busy_o = 0, done_o = 0, stair_o = 0, state = IDLE.
- Shadowing: all cfg_* inputs are captured into shadow registers on an accepted start_i. Changes to cfg_* mid-sweep have no effect.
- Dwell: cfg_dwell_i = 0 is treated as 1.
- Direction: up if shadow stop >= shadow start, otherwise down.
- IDLE:
  - start_i accepted -> LOAD.
- LOAD (1 cycle):
  - step <= shadow start; asg_rst_o = 1; busy_o <= 1; stair <= 0; rep_cnt <= shadow rep; dwell_cnt <= dwell.
  - -> DWELL.
- DWELL:
  - dwell_cnt decrements each cycle.
  - On the cycle it reaches 1: if step == stop -> END, else -> STEP.
- STEP (1 cycle):
  - step <= next; stair increments (saturating); dwell_cnt reloads.
  - -> DWELL.
  - Total per stair = dwell + 1 cycles.
- Next-step arithmetic:
  - Computed at RSZ+49 bits.
  - Up: next = step + inc; if next > stop or carry set, next = stop.
  - Down: next = step - inc; if next < stop or borrow set, next = stop.
  - inc = 0: next = stop.
- END (1 cycle):
  - If rep_cnt != 0: decrement rep_cnt (no decrement when rep = ffff); step <= start; asg_rst_o pulses; stair <= 0; -> DWELL.
  - Otherwise: done_o pulses; busy_o <= 0; -> IDLE.
  - After completion the step output keeps the stop value.
- start == stop: a single stair of dwell cycles, then END.
- abort_i in any state: -> IDLE next cycle; busy_o <= 0; step holds its current value; no done_o.
- abort_i and start_i in the same cycle: abort wins and start is dropped.
- start_i while busy: ignored.
- Latency: step_hi_o / step_lo_o are registered outputs. step equals cfg_start 2 cycles after the start_i pulse.

Optional Feature:
ASG_SWEEP_PINGPONG_EN
- Defined: adds input cfg_pingpong_i (shadowed at start). When set, END swaps the shadow start and stop and inverts direction instead of reloading start; the swap and direction change occur only when another repetition follows (rep_cnt != 0 / infinite), and no asg_rst_o pulse is issued, so phase stays continuous. Each swap counts as one repetition.
- Undefined: the port does not exist and sweeps always restart from start.

Decomposition:
- Shared package red_pitaya_asg_pkg: state encoding constants (IDLE, LOAD, DWELL, STEP, END) and the step-width expression (RSZ+48), both reused by the ASG register bank.
- One sub-module, red_pitaya_asg_sweep_nxt: combinational clamped add/subtract (step, inc, stop, dir -> next). It is isolated for unit testing and timing.

Test Plan:
- start 0x100, stop 0x400, inc 0x100, dwell 3, rep 0 -> steps 0x100/0x200/0x300/0x400 held 4 cycles each; one asg_rst_o pulse; done_o once; stair_o = 3.
- start 0x400, stop 0x150, inc 0x100 (down) -> 0x400, 0x300, 0x200, 0x150 (clamped); done_o pulses.
- inc 0 or overflow case (start near max, inc 0x...FF) -> jumps directly to stop; no wrap-around.
- rep 2 -> three passes, three asg_rst_o pulses, one done_o; rep ffff -> runs until abort_i, then busy_o = 0 with no done_o.
- Async reset asserted mid-DWELL -> all outputs zero immediately, state IDLE; start_i during busy or with simultaneous abort_i -> ignored.
- ASG_SWEEP_PINGPONG_EN, pingpong = 1, 0x100 -> 0x300 with inc 0x100 and rep 1 -> 0x100, 0x200, 0x300, 0x200, 0x100; one asg_rst_o pulse total.

Source files
------------

// File: rtl/red_pitaya_asg_pkg.sv
// Shared ASG definitions: sweep sequencer state encoding and step-word geometry.
// Also used by the ASG register bank so both sides agree on the step width.
package red_pitaya_asg_pkg;

  // Step word layout: RSZ table-address bits + 16 extra integer bits + 32 fraction bits.
  localparam int STEP_FRAC_W  = 32;
  localparam int STEP_INT_EXT = 16;

  // Repetition count that never runs out.
  localparam logic [15:0] REP_INFINITE = 16'hffff;
  // Ceiling of the stair counter.
  localparam logic [15:0] STAIR_MAX    = 16'hffff;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_END   = 3'd4
  } sweep_state_e;

  // Full step-word width for a given table address width.
  function automatic int step_w(input int rsz);
    return rsz + STEP_INT_EXT + STEP_FRAC_W;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_sweep_if.sv
// Bus between the ASG register bank (master) and the sweep sequencer (slave).
// Optional build macro: ASG_SWEEP_PINGPONG_EN adds cfg_pingpong_i.
interface red_pitaya_asg_sweep_if
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ   = 14,
  parameter int CNT_W = 32
) ();

  localparam int SW = step_w(RSZ);

  logic              start_i;
  logic              abort_i;
  logic [SW-1:0]     cfg_start_i;
  logic [SW-1:0]     cfg_stop_i;
  logic [SW-1:0]     cfg_inc_i;
  logic [CNT_W-1:0]  cfg_dwell_i;
  logic [15:0]       cfg_rep_i;
`ifdef ASG_SWEEP_PINGPONG_EN
  logic              cfg_pingpong_i;
`endif
  logic [SW-33:0]    step_hi_o;
  logic [31:0]       step_lo_o;
  logic              asg_rst_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       stair_o;

  modport master (
`ifdef ASG_SWEEP_PINGPONG_EN
    output cfg_pingpong_i,
`endif
    output start_i, abort_i, cfg_start_i, cfg_stop_i, cfg_inc_i, cfg_dwell_i, cfg_rep_i,
    input  step_hi_o, step_lo_o, asg_rst_o, busy_o, done_o, stair_o
  );

  modport slave (
`ifdef ASG_SWEEP_PINGPONG_EN
    input  cfg_pingpong_i,
`endif
    input  start_i, abort_i, cfg_start_i, cfg_stop_i, cfg_inc_i, cfg_dwell_i, cfg_rep_i,
    output step_hi_o, step_lo_o, asg_rst_o, busy_o, done_o, stair_o
  );

endinterface

// File: rtl/red_pitaya_asg_sweep_nxt.sv
// Next stair value for the sweep: clamped add (up) or subtract (down).
// The result never passes the stop value and never wraps; a zero increment
// jumps straight to stop.
module red_pitaya_asg_sweep_nxt
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ = 14
) (
  input  logic [step_w(RSZ)-1:0] step,
  input  logic [step_w(RSZ)-1:0] inc,
  input  logic [step_w(RSZ)-1:0] stop,
  input  logic                   dir_up,
  output logic [step_w(RSZ)-1:0] nxt_step
);

  localparam int SW = step_w(RSZ);

  logic [SW:0] sum_s;
  logic [SW:0] dif_s;

  // One extra bit on both paths exposes carry / borrow for the clamp.
  always_comb begin
    sum_s = {1'b0, step} + {1'b0, inc};
    dif_s = {1'b0, step} - {1'b0, inc};
    if (inc == {SW{1'b0}}) begin
      nxt_step = stop;
    end else if (dir_up) begin
      if (sum_s[SW] || (sum_s[SW-1:0] > stop)) begin
        nxt_step = stop;
      end else begin
        nxt_step = sum_s[SW-1:0];
      end
    end else begin
      if (dif_s[SW] || (dif_s[SW-1:0] < stop)) begin
        nxt_step = stop;
      end else begin
        nxt_step = dif_s[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep sequencer for one ASG channel (dac_clk domain).
// Walks the channel phase increment from start to stop in equal stairs, each
// held dwell+1 cycles, with an optional repeat count (16'hffff = forever).
// Optional build macro: ASG_SWEEP_PINGPONG_EN -- alternate sweep direction on
// each repetition without a pointer reset, keeping the phase continuous.
module red_pitaya_asg_sweep
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ   = 14,
  parameter int CNT_W = 32
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rstn_i,
  red_pitaya_asg_sweep_if.slave bus
);

  localparam int SW = step_w(RSZ);
  localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sweep_state_e     state_r;
  logic [SW-1:0]    start_sh_r;
  logic [SW-1:0]    stop_sh_r;
  logic [SW-1:0]    inc_sh_r;
  logic [CNT_W-1:0] dwell_sh_r;
  logic [CNT_W-1:0] dwell_cnt_r;
  logic [15:0]      rep_cnt_r;
  logic             dir_up_r;
  logic [SW-1:0]    step_r;
  logic             asg_rst_r;
  logic             busy_r;
  logic             done_r;
  logic [15:0]      stair_r;
`ifdef ASG_SWEEP_PINGPONG_EN
  logic             pingpong_r;
`endif

  logic [SW-1:0]    nxt_step_s;
  logic [CNT_W-1:0] dwell_eff_s;

  red_pitaya_asg_sweep_nxt #(
    .RSZ      (RSZ)
  ) u_nxt (
    .step     (step_r),
    .inc      (inc_sh_r),
    .stop     (stop_sh_r),
    .dir_up   (dir_up_r),
    .nxt_step (nxt_step_s)
  );

  // A zero dwell request is served as a one-cycle dwell.
  always_comb begin
    if (bus.cfg_dwell_i == {CNT_W{1'b0}}) begin
      dwell_eff_s = DWELL_ONE;
    end else begin
      dwell_eff_s = bus.cfg_dwell_i;
    end
  end

  // Sweep sequencer: config shadowing, stair timing, repeats and all outputs.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_r     <= ST_IDLE;
      start_sh_r  <= {SW{1'b0}};
      stop_sh_r   <= {SW{1'b0}};
      inc_sh_r    <= {SW{1'b0}};
      dwell_sh_r  <= DWELL_ONE;
      dwell_cnt_r <= {CNT_W{1'b0}};
      rep_cnt_r   <= 16'h0000;
      dir_up_r    <= 1'b1;
      step_r      <= {SW{1'b0}};
      asg_rst_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      stair_r     <= 16'h0000;
`ifdef ASG_SWEEP_PINGPONG_EN
      pingpong_r  <= 1'b0;
`endif
    end else begin
      // Pulses default low; states below raise them for exactly one cycle.
      asg_rst_r <= 1'b0;
      done_r    <= 1'b0;
      if (bus.abort_i) begin
        // Abort beats everything, including a coincident start; step holds.
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.start_i) begin
              start_sh_r <= bus.cfg_start_i;
              stop_sh_r  <= bus.cfg_stop_i;
              inc_sh_r   <= bus.cfg_inc_i;
              dwell_sh_r <= dwell_eff_s;
              rep_cnt_r  <= bus.cfg_rep_i;
              dir_up_r   <= (bus.cfg_stop_i >= bus.cfg_start_i);
`ifdef ASG_SWEEP_PINGPONG_EN
              pingpong_r <= bus.cfg_pingpong_i;
`endif
              state_r    <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            step_r      <= start_sh_r;
            asg_rst_r   <= 1'b1;
            busy_r      <= 1'b1;
            stair_r     <= 16'h0000;
            dwell_cnt_r <= dwell_sh_r;
            state_r     <= ST_DWELL;
          end

          ST_DWELL: begin
            dwell_cnt_r <= dwell_cnt_r - DWELL_ONE;
            if (dwell_cnt_r <= DWELL_ONE) begin
              if (step_r == stop_sh_r) begin
                state_r <= ST_END;
              end else begin
                state_r <= ST_STEP;
              end
            end
          end

          ST_STEP: begin
            step_r      <= nxt_step_s;
            dwell_cnt_r <= dwell_sh_r;
            if (stair_r != STAIR_MAX) begin
              stair_r <= stair_r + 16'd1;
            end
            state_r     <= ST_DWELL;
          end

          ST_END: begin
            if (rep_cnt_r != 16'h0000) begin
              if (rep_cnt_r != REP_INFINITE) begin
                rep_cnt_r <= rep_cnt_r - 16'd1;
              end
              stair_r     <= 16'h0000;
              dwell_cnt_r <= dwell_sh_r;
              state_r     <= ST_DWELL;
`ifdef ASG_SWEEP_PINGPONG_EN
              if (pingpong_r) begin
                // Turn around at the current value; no pointer reset.
                start_sh_r <= stop_sh_r;
                stop_sh_r  <= start_sh_r;
                dir_up_r   <= ~dir_up_r;
              end else begin
                step_r    <= start_sh_r;
                asg_rst_r <= 1'b1;
              end
`else
              step_r    <= start_sh_r;
              asg_rst_r <= 1'b1;
`endif
            end else begin
              // Final pass finished; step keeps the stop value.
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end

          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.step_hi_o = step_r[SW-1:STEP_FRAC_W];
  assign bus.step_lo_o = step_r[STEP_FRAC_W-1:0];
  assign bus.asg_rst_o = asg_rst_r;
  assign bus.busy_o    = busy_r;
  assign bus.done_o    = done_r;
  assign bus.stair_o   = stair_r;

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Self-checking bench for red_pitaya_asg_sweep: directed vector table, corner
// sequences (abort, infinite repeat, async reset) and random sweeps, all
// checked cycle-by-cycle against a stair-list reference model.
module tb_red_pitaya_asg_sweep;

  localparam int RSZ   = 14;
  localparam int CNT_W = 32;
  localparam int SW    = RSZ + 48;
  localparam logic [63:0] MASK = (64'd1 << SW) - 64'd1;

  logic dac_clk_i  = 1'b0;
  logic dac_rstn_i = 1'b0;

  always #5 dac_clk_i = ~dac_clk_i;

  red_pitaya_asg_sweep_if #(.RSZ(RSZ), .CNT_W(CNT_W)) bus ();

  red_pitaya_asg_sweep #(.RSZ(RSZ), .CNT_W(CNT_W)) dut (
    .dac_clk_i  (dac_clk_i),
    .dac_rstn_i (dac_rstn_i),
    .bus        (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [63:0] step;
    logic        rst;
    logic        busy;
    logic        done;
    logic [15:0] stair;
  } smp_t;

  smp_t exp_q[$];

  typedef struct {
    logic [63:0] s;
    logic [63:0] e;
    logic [63:0] inc;
    logic [31:0] dw;
    logic [15:0] rep;
    bit          pp;
    int          inj;
    logic [63:0] x_step;
    int          x_rst;
    int          x_done;
    int          x_busy;
    logic [15:0] x_stair;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [63:0] dut_step();
    logic [63:0] v;
    v = 64'd0;
    v[SW-1:0] = {bus.step_hi_o, bus.step_lo_o};
    return v;
  endfunction

  function automatic logic [63:0] dut_flags();
    return {45'd0, bus.asg_rst_o, bus.busy_o, bus.done_o, bus.stair_o};
  endfunction

  function automatic logic [63:0] exp_flags(input smp_t x);
    return {45'd0, x.rst, x.busy, x.done, x.stair};
  endfunction

  // Reference: list the stair values of each pass, hold each dwell+1 samples.
  function automatic void build_model(input logic [63:0] s, input logic [63:0] e,
                                      input logic [63:0] inc, input logic [31:0] dw,
                                      input logic [15:0] rep, input bit pp);
    logic [63:0] lst[$];
    logic [63:0] a, b, cur, nx;
    int d, passes;
    smp_t x;
    exp_q.delete();
    d = (dw == 32'd0) ? 1 : int'(dw);
    passes = int'(rep) + 1;
    a = s;
    b = e;
    for (int p = 0; p < passes; p++) begin
      lst.delete();
      cur = a;
      lst.push_back(cur);
      while (cur != b) begin
        if (inc == 64'd0) nx = b;
        else if (b >= a) begin
          nx = cur + inc;
          if (nx > b) nx = b;
        end else begin
          if (inc > cur - b) nx = b;
          else nx = cur - inc;
        end
        cur = nx;
        lst.push_back(cur);
      end
      for (int i = 0; i < lst.size(); i++) begin
        for (int c = 0; c <= d; c++) begin
          x.step  = lst[i];
          x.rst   = (c == 0) && (i == 0) && ((p == 0) || !pp);
          x.busy  = 1'b1;
          x.done  = 1'b0;
          x.stair = 16'(i);
          exp_q.push_back(x);
        end
      end
      if (pp) begin
        nx = a;
        a  = b;
        b  = nx;
      end
    end
    x = exp_q[exp_q.size()-1];
    x.rst  = 1'b0;
    x.busy = 1'b0;
    x.done = 1'b1;
    exp_q.push_back(x);
    x.done = 1'b0;
    exp_q.push_back(x);
    exp_q.push_back(x);
  endfunction

  task automatic drive_cfg(input logic [63:0] s, input logic [63:0] e, input logic [63:0] inc,
                           input logic [31:0] dw, input logic [15:0] rep);
    bus.cfg_start_i = s[SW-1:0];
    bus.cfg_stop_i  = e[SW-1:0];
    bus.cfg_inc_i   = inc[SW-1:0];
    bus.cfg_dwell_i = dw;
    bus.cfg_rep_i   = rep;
  endtask

  // Starts a sweep and compares every sample with the model; at sample inj a
  // second start with scrambled config is issued, which must have no effect.
  task automatic run_sweep(input logic [63:0] s, input logic [63:0] e, input logic [63:0] inc,
                           input logic [31:0] dw, input logic [15:0] rep, input bit pp,
                           input int inj, input string tag,
                           output logic [63:0] last_step, output int rst_cnt,
                           output int done_cnt, output int busy_cnt, output logic [15:0] last_stair);
    build_model(s, e, inc, dw, rep, pp);
    rst_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
    drive_cfg(s, e, inc, dw, rep);
`ifdef ASG_SWEEP_PINGPONG_EN
    bus.cfg_pingpong_i = pp;
`endif
    bus.start_i = 1'b1;
    @(negedge dac_clk_i);
    bus.start_i = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == inj) begin
        bus.start_i = 1'b1;
        drive_cfg(~s & MASK, ~e & MASK, inc ^ 64'h55, dw + 32'd7, rep + 16'd1);
`ifdef ASG_SWEEP_PINGPONG_EN
        bus.cfg_pingpong_i = ~pp;
`endif
      end
      @(negedge dac_clk_i);
      bus.start_i = 1'b0;
      check($sformatf("%s.step[%0d]", tag, k), dut_step(), exp_q[k].step);
      check($sformatf("%s.flags[%0d]", tag, k), dut_flags(), exp_flags(exp_q[k]));
      rst_cnt  += int'(bus.asg_rst_o);
      done_cnt += int'(bus.done_o);
      busy_cnt += int'(bus.busy_o);
    end
    last_step  = dut_step();
    last_stair = bus.stair_o;
  endtask

  initial begin
    logic [63:0] ls;
    logic [15:0] lst_stair;
    int rc, dc, bc;
    logic [63:0] held;

    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    drive_cfg(64'd0, 64'd0, 64'd0, 32'd0, 16'd0);
`ifdef ASG_SWEEP_PINGPONG_EN
    bus.cfg_pingpong_i = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge dac_clk_i);
    check("rst.step", dut_step(), 64'd0);
    check("rst.flags", dut_flags(), 64'd0);
    dac_rstn_i = 1'b1;
    @(negedge dac_clk_i);
    check("post_rst.flags", dut_flags(), 64'd0);

    // Abort and start together: start must be dropped
    drive_cfg(64'h777, 64'h999, 64'h100, 32'd2, 16'd0);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge dac_clk_i);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    check("abort_start.busy0", 64'(bus.busy_o), 64'd0);
    repeat (2) @(negedge dac_clk_i);
    check("abort_start.busy1", 64'(bus.busy_o), 64'd0);
    check("abort_start.step", dut_step(), 64'd0);

    // Directed vector table
    vecs.push_back('{s:64'h100, e:64'h400, inc:64'h100, dw:32'd3, rep:16'd0, pp:1'b0, inj:-1,
                     x_step:64'h400, x_rst:1, x_done:1, x_busy:16, x_stair:16'd3});
    vecs.push_back('{s:64'h400, e:64'h150, inc:64'h100, dw:32'd2, rep:16'd0, pp:1'b0, inj:5,
                     x_step:64'h150, x_rst:1, x_done:1, x_busy:12, x_stair:16'd3});
    vecs.push_back('{s:64'h100, e:64'h500, inc:64'h0, dw:32'd1, rep:16'd0, pp:1'b0, inj:-1,
                     x_step:64'h500, x_rst:1, x_done:1, x_busy:4, x_stair:16'd1});
    vecs.push_back('{s:64'h3FFF_FFFF_FFFF_FFEF, e:64'h3FFF_FFFF_FFFF_FFFF,
                     inc:64'h3FFF_FFFF_FFFF_FFFF, dw:32'd1, rep:16'd0, pp:1'b0, inj:-1,
                     x_step:64'h3FFF_FFFF_FFFF_FFFF, x_rst:1, x_done:1, x_busy:4, x_stair:16'd1});
    vecs.push_back('{s:64'h1_0000_0000, e:64'h2_8000_0000, inc:64'h1_0000_0000, dw:32'd1,
                     rep:16'd0, pp:1'b0, inj:-1,
                     x_step:64'h2_8000_0000, x_rst:1, x_done:1, x_busy:6, x_stair:16'd2});
    vecs.push_back('{s:64'h300, e:64'h0, inc:64'h3FFF_FFFF_FFFF_FFFF, dw:32'd1, rep:16'd0,
                     pp:1'b0, inj:-1, x_step:64'h0, x_rst:1, x_done:1, x_busy:4, x_stair:16'd1});
    vecs.push_back('{s:64'h200, e:64'h200, inc:64'h100, dw:32'd5, rep:16'd0, pp:1'b0, inj:2,
                     x_step:64'h200, x_rst:1, x_done:1, x_busy:6, x_stair:16'd0});
    vecs.push_back('{s:64'h100, e:64'h300, inc:64'h100, dw:32'd1, rep:16'd2, pp:1'b0, inj:10,
                     x_step:64'h300, x_rst:3, x_done:1, x_busy:18, x_stair:16'd2});
    vecs.push_back('{s:64'h10, e:64'h30, inc:64'h10, dw:32'd0, rep:16'd0, pp:1'b0, inj:-1,
                     x_step:64'h30, x_rst:1, x_done:1, x_busy:6, x_stair:16'd2});
`ifdef ASG_SWEEP_PINGPONG_EN
    vecs.push_back('{s:64'h100, e:64'h300, inc:64'h100, dw:32'd1, rep:16'd1, pp:1'b1, inj:-1,
                     x_step:64'h100, x_rst:1, x_done:1, x_busy:12, x_stair:16'd2});
`endif

    for (int v = 0; v < vecs.size(); v++) begin
      run_sweep(vecs[v].s, vecs[v].e, vecs[v].inc, vecs[v].dw, vecs[v].rep, vecs[v].pp,
                vecs[v].inj, $sformatf("vec%0d", v), ls, rc, dc, bc, lst_stair);
      check($sformatf("vec%0d.final_step", v), ls, vecs[v].x_step);
      check($sformatf("vec%0d.rst_pulses", v), 64'(rc), 64'(vecs[v].x_rst));
      check($sformatf("vec%0d.done_pulses", v), 64'(dc), 64'(vecs[v].x_done));
      check($sformatf("vec%0d.busy_cycles", v), 64'(bc), 64'(vecs[v].x_busy));
      check($sformatf("vec%0d.stair", v), 64'(lst_stair), 64'(vecs[v].x_stair));
    end

    // Infinite repeat, then abort during the END cycle of the fifth pass
    build_model(64'h10, 64'h30, 64'h10, 32'd1, 16'd4, 1'b0);
    drive_cfg(64'h10, 64'h30, 64'h10, 32'd1, 16'hffff);
`ifdef ASG_SWEEP_PINGPONG_EN
    bus.cfg_pingpong_i = 1'b0;
`endif
    bus.start_i = 1'b1;
    @(negedge dac_clk_i);
    bus.start_i = 1'b0;
    rc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge dac_clk_i);
      check($sformatf("inf.step[%0d]", k), dut_step(), exp_q[k].step);
      check($sformatf("inf.flags[%0d]", k), dut_flags(), exp_flags(exp_q[k]));
      rc += int'(bus.asg_rst_o);
    end
    check("inf.rst_pulses", 64'(rc), 64'd5);
    held = exp_q[29].step;
    bus.abort_i = 1'b1;
    @(negedge dac_clk_i);
    bus.abort_i = 1'b0;
    check("inf.abort_busy", 64'(bus.busy_o), 64'd0);
    check("inf.abort_step", dut_step(), held);
    dc = 0;
    bc = 0;
    for (int k = 0; k < 5; k++) begin
      dc += int'(bus.done_o);
      bc += int'(bus.busy_o);
      @(negedge dac_clk_i);
    end
    check("inf.abort_no_done", 64'(dc), 64'd0);
    check("inf.abort_idle", 64'(bc), 64'd0);

    // Async reset in the middle of a dwell
    drive_cfg(64'h500, 64'h900, 64'h100, 32'd10, 16'd0);
    bus.start_i = 1'b1;
    @(negedge dac_clk_i);
    bus.start_i = 1'b0;
    repeat (3) @(negedge dac_clk_i);
    check("arst.pre_busy", 64'(bus.busy_o), 64'd1);
    check("arst.pre_step", dut_step(), 64'h500);
    #2 dac_rstn_i = 1'b0;
    #1;
    check("arst.step", dut_step(), 64'd0);
    check("arst.flags", dut_flags(), 64'd0);
    @(negedge dac_clk_i);
    dac_rstn_i = 1'b1;
    bc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge dac_clk_i);
      bc += int'(bus.busy_o) + int'(bus.done_o) + int'(bus.asg_rst_o);
    end
    check("arst.stays_idle", 64'(bc), 64'd0);

    // Random sweeps against the model
    for (int it = 0; it < 24; it++) begin
      logic [63:0] s, e, inc, rng;
      logic [31:0] dw;
      logic [15:0] rep;
      bit pp;
      int dv, inj;
      if (it % 2 == 1) begin
        s = {$urandom, $urandom} & MASK;
        e = {$urandom, $urandom} & MASK;
      end else begin
        s = 64'($urandom_range(0, 4095));
        e = 64'($urandom_range(0, 4095));
      end
      rng = (e >= s) ? e - s : s - e;
      dv  = $urandom_range(1, 6);
      inc = rng / 64'(dv) + 64'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) inc = 64'd0;
      dw  = 32'($urandom_range(0, 3));
      rep = 16'($urandom_range(0, 2));
      pp  = 1'b0;
`ifdef ASG_SWEEP_PINGPONG_EN
      pp  = 1'($urandom_range(0, 1));
`endif
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : -1;
      run_sweep(s, e, inc, dw, rep, pp, inj, $sformatf("rnd%0d", it), ls, rc, dc, bc, lst_stair);
      check($sformatf("rnd%0d.done_pulses", it), 64'(dc), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
